switch_debouncer: RTL

Conditions the raw board switches before they reach the switch/register data multiplexer on the register-file read path. Each switch is brought into the core clock domain through a two-flop synchroniser, then optionally debounced by a shared sample-tick filter. The block presents a stable `[`SWITCH_WIDTH-2:0]` switch vector and a one-cycle pulse on each debounced press of switch 8, the program's "go" input.

---
 rtl/switch_debouncer.sv | 83 ++++++++
 1 files changed

// File: rtl/switch_debouncer.sv
// Two-flop synchroniser plus shared sample-tick debounce filter for the board switches.
// Define SW_DEBOUNCE_EN to build the prescaler/filter; otherwise switches follow the synchroniser.
`ifndef SWITCH_WIDTH
`define SWITCH_WIDTH 10
`endif

module switch_debouncer #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [`SWITCH_WIDTH-2:0] raw_switches,
  output logic [`SWITCH_WIDTH-2:0] switches,
  output logic                     sw8_rise
);

  localparam int W = `SWITCH_WIDTH - 1;

  if (DEBOUNCE_CYCLES < 2) begin : g_param_check
    $error("switch_debouncer: DEBOUNCE_CYCLES must be at least 2");
  end

  logic [W-1:0] sync1;
  logic [W-1:0] sync2;
  logic         sw8_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_switches;
      sync2 <= sync1;
    end
  end

`ifdef SW_DEBOUNCE_EN
  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt;
  logic          tick;
  logic [W-1:0]  sample;
  logic [W-1:0]  agree;

  assign tick  = (cnt == CNT_LAST);
  // a bit may only move when this tick and the previous one saw the same level
  assign agree = ~(sync2 ^ sample);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample   <= '0;
      switches <= '0;
    end else if (tick) begin
      sample   <= sync2;
      switches <= (switches & ~agree) | (sync2 & agree);
    end
  end
`else
  assign switches = sync2;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw8_q    <= 1'b0;
      sw8_rise <= 1'b0;
    end else begin
      sw8_q    <= switches[W-1];
      sw8_rise <= switches[W-1] & ~sw8_q;
    end
  end

endmodule
